// File: rtl/seq_add64_ctrl.sv
// rtl/seq_add64_ctrl.sv - slice-serial W-bit adder reusing one SLICE_W-bit ripple-carry slice
module seq_add64_ctrl #(
  parameter int SLICE_W  = 8,
  parameter int N_SLICES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [SLICE_W*N_SLICES-1:0] a,
  input  logic [SLICE_W*N_SLICES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [SLICE_W*N_SLICES-1:0] sum,
  output logic                        cout,
  output logic                        overflow
);

  localparam int W     = SLICE_W * N_SLICES;
  localparam int CNT_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [W-1:0]       la;
  logic [W-1:0]       lb;
  logic [CNT_W-1:0]   cnt;
  logic               c;

  int                 base;
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] ss;
  logic [SLICE_W:0]   ch;

  // Shared slice adder: selects slice cnt of the latched operands and ripples the carry bit by bit
  always_comb begin
    base  = int'(cnt) * SLICE_W;
    sa    = la[base +: SLICE_W];
    sb    = lb[base +: SLICE_W];
    ss    = '0;
    ch    = '0;
    ch[0] = c;
    for (int i = 0; i < SLICE_W; i++) begin
      ss[i]   = sa[i] ^ sb[i] ^ ch[i];
      ch[i+1] = (sa[i] & sb[i]) | (ch[i] & (sa[i] ^ sb[i]));
    end
  end

  // Control FSM and result registers; reset wins over start and over RUN progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      la       <= '0;
      lb       <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            la    <= a;
            lb    <= b;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[base +: SLICE_W] <= ss;
          c                    <= ch[SLICE_W];
          if (cnt == LAST) begin
            cnt      <= '0;
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= ch[SLICE_W];
            // Signed overflow: carry into the sign bit differs from carry out of it
            overflow <= ch[SLICE_W-1] ^ ch[SLICE_W];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add64_ctrl.sv
// tb/tb_seq_add64_ctrl.sv - self-checking bench for seq_add64_ctrl against an arithmetic reference model
module tb_seq_add64_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        overflow;

  int n_pass;
  int n_total;

  seq_add64_ctrl #(.SLICE_W(8), .N_SLICES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 65-bit addition and sign-rule overflow
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y, input logic ci);
    logic [64:0] full;
    logic        ov;
    full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    ov   = (x[63] == y[63]) && (full[63] != x[63]);
    return {ov, full};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: verifies busy for 8 cycles, then the done cycle and model result
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic ci, input string tag);
    logic [65:0] r;
    r     = ref_add(x, y, ci);
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = ci;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check({tag, " busy"}, {63'd0, busy}, 64'd1);
      check({tag, " no_done"}, {63'd0, done}, 64'd0);
      tick();
    end
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " busy_low"}, {63'd0, busy}, 64'd0);
    check({tag, " sum"}, sum, r[63:0]);
    check({tag, " cout"}, {63'd0, cout}, {63'd0, r[64]});
    check({tag, " ovf"}, {63'd0, overflow}, {63'd0, r[65]});
    tick();
  endtask

  initial begin
    logic [65:0] r;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [63:0] cap;
    int          ndone;

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;
    tick();
    tick();

    // Reset state, with start asserted to show reset has priority
    start = 1'b1;
    a     = 64'h1234;
    tick();
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst sum", sum, 64'd0);
    check("rst cout", {63'd0, cout}, 64'd0);
    check("rst ovf", {63'd0, overflow}, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    run_op(64'h57, 64'h07, 1'b1, "small");
    check("small sum const", sum, 64'h5F);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "ripple");
    check("ripple cout const", {63'd0, cout}, 64'd1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "sovf");
    check("sovf sum const", sum, 64'h8000_0000_0000_0000);

    // Results hold while idle even though inputs change
    r = ref_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    a = 64'hDEAD_BEEF;
    b = 64'hCAFE;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold sum", sum, r[63:0]);
      check("hold done", {63'd0, done}, 64'd0);
    end
    check("hold ovf", {63'd0, overflow}, {63'd0, r[65]});

    // Randomized operations
    for (int t = 0; t < 16; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (t == 0) rb = ~ra;
      run_op(ra, rb, rc, "rand");
    end

    // start with new operands during RUN cycle 3 is ignored
    r     = ref_add(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
    start = 1'b1;
    a     = 64'h1111_2222_3333_4444;
    b     = 64'h0F0F_0F0F_0F0F_0F0F;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    cap   = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) begin
        start = 1'b1;
        a     = 64'hFFFF_0000_FFFF_0000;
        b     = 64'h1;
        cin   = 1'b0;
      end
      if (k == 3) start = 1'b0;
      tick();
      if (done) begin
        ndone++;
        cap = sum;
        check("ignore latency", 64'(k), 64'd8);
      end
    end
    check("ignore ndone", 64'(ndone), 64'd1);
    check("ignore sum", cap, r[63:0]);

    // Reset during slice 3 aborts, then start is taken on the first edge after release
    start = 1'b1;
    a     = 64'hFFFF_FFFF_FFFF_FFFF;
    b     = 64'hFFFF_FFFF_FFFF_FFFF;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort sum", sum, 64'd0);
    check("abort cout", {63'd0, cout}, 64'd0);
    check("abort ovf", {63'd0, overflow}, 64'd0);
    run_op(64'd1, 64'd1, 1'b0, "after_rst");
    check("after_rst sum const", sum, 64'd2);

    // start held high: done every 9 cycles, busy low only on done cycles
    start = 1'b1;
    a     = 64'h10;
    b     = 64'h20;
    cin   = 1'b0;
    tick();
    for (int k = 1; k <= 27; k++) begin
      tick();
      check("b2b done", {63'd0, done}, ((k % 9) == 8) ? 64'd1 : 64'd0);
      check("b2b busy", {63'd0, busy}, ((k % 9) == 8) ? 64'd0 : 64'd1);
      if ((k % 9) == 8) check("b2b sum", sum, 64'h30);
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("final idle busy", {63'd0, busy}, 64'd0);
    check("final idle done", {63'd0, done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
